axis_write_arbiter: RTL
=======================

# axis_write_arbiter

Round-robin arbiter that shares one downstream AXI4-Stream write channel among `NUM_PORTS` single-beat requesters, such as register-write streams produced by AXI4-Lite-to-stream bridges. It grants one port at a time for a bounded burst of beats, registers the selected beat onto the master side with full `tready` backpressure, and tags each beat with the source port index. It sits between several control-plane writers and one shared configuration or FIFO sink.

## Interface
- `NUM_PORTS`, default 4: number of slave ports, 2..16.
- `AXIS_TDATA_WIDTH`, default 32: beat width.
- `BURST_LEN`, default 4: maximum beats per grant, 1..255.
- `aclk`  in  1: clock. All logic is on the rising edge.
- `areset`  in  1: reset. It is asynchronous and active-high, and it clears all state immediately.
- `s_axis_tdata`  in  NUM_PORTS*AXIS_TDATA_WIDTH: per-port data. Port k occupies bits [k*W +: W].
- `s_axis_tvalid`  in  NUM_PORTS: per-port valid.
- `s_axis_tready`  out  NUM_PORTS: per-port ready. It is one-hot or zero.
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH: registered output data.
- `m_axis_tuser`  out  IDX_W = max(1, clog2(NUM_PORTS)): source port index of the current beat.
- `m_axis_tvalid`  out  1: registered output valid.
- `m_axis_tready`  in  1: downstream ready.
- `grant_active`  out  1: high while in GRANT state.

## Operation
- There are two states: IDLE and GRANT. Registers:
  - `ptr`: round-robin start index.
  - `sel`: granted port.
  - `cnt`: beats accepted in the current grant, 8-bit.
  - Output register: `m_axis_tdata`, `m_axis_tuser`, `m_axis_tvalid`.
- **IDLE:** if any `s_axis_tvalid` bit is set, choose the first set bit searching from `ptr` upward with wrap at NUM_PORTS-1→0. Then `sel`←that index, `cnt`←0, and go to GRANT. If no bit is set, stay in IDLE. No beat is accepted in IDLE.
- **GRANT:** `s_axis_tready[sel] = (~m_axis_tvalid | m_axis_tready)`. All other ready bits are 0.
  - **Accept:** when `s_axis_tvalid[sel] & s_axis_tready[sel]`, the output register loads that port's data, `m_axis_tuser`←`sel`, `m_axis_tvalid`←1, and `cnt`←`cnt`+1.
  - **Release on burst limit:** when the accepted beat makes `cnt` equal `BURST_LEN`, go to IDLE with `ptr`←`sel`+1 (wrapping).
  - **Release on drop:** when `s_axis_tvalid[sel]`=0 and the output register can accept, go to IDLE with `ptr`←`sel`+1, even if `cnt`=0.
  - **Output drain:** the output register clears `m_axis_tvalid` when `m_axis_tready` is high and no new beat loads in the same cycle.
- **Simultaneous load and drain:** a new beat overwrites the register in the same cycle the old beat is taken, so `tvalid` stays 1.
- **Stall:** while `m_axis_tvalid & ~m_axis_tready`, all slave readies are 0. Held `tdata`/`tuser` must not change.
- **Reset mid-operation:**
  - State←IDLE, `ptr`←0, `sel`←0, `cnt`←0.
  - `m_axis_tvalid`←0, `m_axis_tdata`←0, `m_axis_tuser`←0.
  - Any beat in the output register is discarded.
- **Reset values of outputs:** `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tuser`=0, `grant_active`=0.

## Timing
- **Arbitration:** 1 cycle. Valid seen in IDLE at edge N gives GRANT from edge N+1, and the first ready appears in cycle N+1.
- **Latency:** a beat accepted at edge M appears on `m_axis_*` after edge M.
- **Throughput:** 1 beat/cycle within a grant while `m_axis_tready`=1. Each grant change costs exactly one IDLE cycle.
- **Fairness:** with all ports continuously valid, grants rotate 0,1,2,3,0…, each delivering exactly `BURST_LEN` beats.
- **Stability:** `s_axis_tready` and `grant_active` depend only on registered state and `m_axis_tready`. There is no combinational path from `s_axis_tvalid` to `s_axis_tready`.

## Structure
- Shared package `axis_write_arbiter_pkg` holds:
  - the state enum {IDLE, GRANT};
  - a `clog2`-based `IDX_W` function;
  - the `BURST_LEN` width constant, 8.
- One sub-module, `rr_priority_select`, is natural. Its inputs are the request vector and `ptr`; its outputs are `found` and `index`. It is purely combinational, with rotate, find-first and un-rotate steps.

## Test plan
- **Single port:** only port 2 is valid with data 0xA0..0xA5 and `BURST_LEN`=4, ready always high.
  - Beats 0xA0–0xA3 appear with tuser=2, then one gap cycle, then 0xA4–0xA5.
- **All four ports continuously valid:** the output tuser sequence is 0×4, 1×4, 2×4, 3×4, 0×4, with one idle cycle between groups.
- **Backpressure:** `m_axis_tready` is held low for 5 cycles mid-burst.
  - `tdata`/`tuser` stay constant and all `s_axis_tready`=0.
  - On release, there is no beat loss or duplication (scoreboard per port).
- **Early drop:** port 1 deasserts valid after 2 beats while port 3 is valid.
  - The grant moves to port 3 after one IDLE cycle, and `ptr` becomes 2.
- **Wrap:** `ptr`=3 and only port 0 is valid, so port 0 is granted.
- **Async reset mid-burst:** `areset` is pulsed high between clock edges.
  - `m_axis_tvalid` and `s_axis_tready` drop to 0 immediately.
  - After release, arbitration restarts at port 0.

Source files
------------

// File: rtl/axis_write_arbiter_pkg.sv
// Shared types and constants for the AXI4-Stream write arbiter.
// No logic of its own.
// Not applicable: no handshake.
package axis_write_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Width of the per-grant beat counter, which bounds BURST_LEN to 255.
    localparam int CNT_W = 8;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_write_arbiter_rr_priority_select.sv
// Round-robin pick: first set request at or above ptr_i, wrapping.
// Purely combinational, zero cycles.
// Not applicable: no handshake.
module rr_priority_select #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 found_o,
    output logic [IDX_W-1:0]     index_o
);

    localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(NUM_PORTS);

    logic [NUM_PORTS-1:0] rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;

    always_comb begin
        rot     = (req_i >> ptr_i) | (req_i << (NUM_PORTS - int'(ptr_i)));
        found_o = 1'b0;
        off     = '0;
        // Descending scan so the lowest rotated bit wins.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_o = 1'b1;
                off     = IDX_W'(i);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= N_L) begin
            sum = sum - N_L;
        end
        index_o = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/axis_write_arbiter.sv
// Round-robin N:1 AXI4-Stream write arbiter with bounded bursts and source tagging.
// One IDLE cycle to arbitrate; accepted beat is on m_axis one cycle after its handshake.
// Slave ready only for the granted port and only when the output register is empty or draining.
module axis_write_arbiter
    import axis_write_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS        = 4,
    parameter  int AXIS_TDATA_WIDTH = 32,
    parameter  int BURST_LEN        = 4,
    localparam int IDX_W            = idx_w(NUM_PORTS)
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                  s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
    output logic [IDX_W-1:0]                      m_axis_tuser,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  grant_active
);

    arb_state_e                  state_q, state_d;
    logic [IDX_W-1:0]            ptr_q, ptr_d;
    logic [IDX_W-1:0]            sel_q, sel_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [IDX_W-1:0]            tuser_q, tuser_d;
    logic                        tvalid_q, tvalid_d;

    logic                        pick_found;
    logic [IDX_W-1:0]            pick_idx;
    logic [IDX_W-1:0]            sel_next;
    logic [CNT_W-1:0]            cnt_inc;
    logic [AXIS_TDATA_WIDTH-1:0] sel_dat;
    logic                        sel_vld;
    logic                        out_free;
    logic [NUM_PORTS-1:0]        rdy;

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req_i   (s_axis_tvalid),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .index_o (pick_idx)
    );

    assign out_free = ~tvalid_q | m_axis_tready;
    assign sel_vld  = s_axis_tvalid[sel_q];
    assign sel_dat  = s_axis_tdata[int'(sel_q)*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign sel_next = (sel_q == IDX_W'(NUM_PORTS - 1)) ? '0 : sel_q + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tvalid_d = tvalid_q;
        rdy      = '0;

        // Drain by default; a load below overrides it in the same cycle.
        if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                rdy[sel_q] = out_free;
                if (out_free && sel_vld) begin
                    tdata_d  = sel_dat;
                    tuser_d  = sel_q;
                    tvalid_d = 1'b1;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == CNT_W'(BURST_LEN)) begin
                        state_d = IDLE;
                        ptr_d   = sel_next;
                    end
                end else if (out_free) begin
                    state_d = IDLE;
                    ptr_d   = sel_next;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign s_axis_tready = rdy;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign grant_active  = (state_q == GRANT);

endmodule
